// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap control and a saturating match counter.
// Compares the last len accepted bits against a loaded pattern; flag, match_cnt and armed are registered.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din_vld,
    input  logic               din,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               flag,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_e;

    localparam logic [LEN_W-1:0]   LEN_MIN = LEN_W'(2);
    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_RST = (MAX_LEN < 4) ? LEN_W'(MAX_LEN) : LEN_W'(4);
    localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_ZERO = LEN_W'(0);
    localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(4'b0110);
    localparam logic [MAX_LEN-1:0] PAT_ZERO = MAX_LEN'(1'b0);
    localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l < LEN_MIN) begin
            clamp_len = LEN_MIN;
        end else if (l > LEN_MAX) begin
            clamp_len = LEN_MAX;
        end else begin
            clamp_len = l;
        end
    endfunction

    // Selects the low l bits, so pattern bits at or above len never take part in a compare.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
        len_mask = PAT_ZERO;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < l);
        end
    endfunction

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q;
    state_e             state_q, state_d;

    logic [MAX_LEN-1:0] nh_s;
    logic [LEN_W-1:0]   nf_s;
    logic               hit_s;
    logic               accept_s;
    logic               match_s;

    // Datapath next-state: config load, history shift, match detection and counter.
    always_comb begin
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        flag_d   = 1'b0;
        cnt_d    = cnt_q;
        accept_s = din_vld & ~cfg_we;
        nh_s     = {hist_q[MAX_LEN-2:0], din};
        nf_s     = (fill_q >= len_q) ? len_q : (fill_q + LEN_ONE);
        hit_s    = (nf_s == len_q) && (((nh_s ^ pat_q) & len_mask(len_q)) == PAT_ZERO);
        match_s  = accept_s & hit_s;

        if (cfg_we) begin
            pat_d  = cfg_pat;
            len_d  = clamp_len(cfg_len);
            ovl_d  = cfg_ovl;
            hist_d = PAT_ZERO;
            fill_d = LEN_ZERO;
        end else if (din_vld) begin
            hist_d = nh_s;
            if (hit_s) begin
                flag_d = 1'b1;
                fill_d = ovl_q ? len_q : LEN_ZERO;
            end else begin
                fill_d = nf_s;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end

        // A clear coinciding with a match leaves that match counted.
        if (match_s) begin
            if (cnt_clr) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (cnt_clr) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Control FSM next-state: tracks whether the history holds len valid bits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (accept_s && (nf_s == len_q) && !(hit_s && !ovl_q)) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_ARMED: begin
                if (cfg_we || (match_s && !ovl_q)) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q   <= PAT_RST;
            len_q   <= LEN_RST;
            ovl_q   <= 1'b1;
            hist_q  <= PAT_ZERO;
            fill_q  <= LEN_ZERO;
            flag_q  <= 1'b0;
            cnt_q   <= CNT_ZERO;
            state_q <= ST_FILL;
            armed_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            armed_q <= (state_d == ST_ARMED);
        end
    end

    assign flag      = flag_q;
    assign match_cnt = cnt_q;
    assign armed     = armed_q;

endmodule
